// File: rtl/scoreboard_scan_ctrl.sv
// Digit-scan sequencer: one-hot digit select, phased anode enables and a double-buffered BCD score.
// Optional leading-zero blanking is enabled by defining SCAN_LZB_EN.
module scoreboard_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score_in,
  input  logic        load,
  output logic [3:0]  code,
  output logic [3:0]  an,
  output logic [3:0]  digit_bcd,
  output logic        digit_blank,
  output logic        frame_start,
  output logic        pending
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             frame_start_q, frame_start_d;
  logic             slot_wrap;
  logic             frame_wrap;

  always_comb begin
    slot_wrap     = (cnt_q == CNT_MAX);
    frame_wrap    = slot_wrap && code_q[3];
    cnt_d         = slot_wrap ? '0 : cnt_q + CNT_W'(1);
    code_d        = slot_wrap ? {code_q[2:0], code_q[3]} : code_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    frame_start_d = frame_wrap;

    if (frame_wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A load landing on the transfer edge is the next score, so it re-arms pending.
    if (load) begin
      shadow_d  = score_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      code_q        <= 4'b0001;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign code        = code_q;
  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign an          = (cnt_q < BLANK_LIM) ? 4'b1111 : ~code_q;

  assign digit_bcd = ({4{code_q[0]}} & active_q[3:0])
                   | ({4{code_q[1]}} & active_q[7:4])
                   | ({4{code_q[2]}} & active_q[11:8])
                   | ({4{code_q[3]}} & active_q[15:12]);

`ifdef SCAN_LZB_EN
  logic [3:0] lead_zero;

  // Slot i is a leading zero when it and every higher nibble are zero; slot 0 always shows.
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (active_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (active_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (active_q[7:4] == 4'd0);
  end

  assign digit_blank = |(code_q & lead_zero);
`else
  assign digit_blank = 1'b0;
`endif

endmodule

// File: tb/tb_scoreboard_scan_ctrl.sv
// Directed self-checking bench for scoreboard_scan_ctrl with PRESCALE=8, BLANK_CYCLES=2.
module tb_scoreboard_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] score_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  code;
  logic [3:0]  an;
  logic [3:0]  digit_bcd;
  logic        digit_blank;
  logic        frame_start;
  logic        pending;

  int checks = 0;
  int failures = 0;

  scoreboard_scan_ctrl #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .score_in(score_in), .load(load),
    .code(code), .an(an), .digit_bcd(digit_bcd), .digit_blank(digit_blank),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the falling edge of cycle 0 (cnt=0, code=0001) with rst released.
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] exp_code;
    logic [3:0] exp_an;
    logic       exp_fs;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      exp_code = 4'b0001 << ((k / 8) % 4);
      exp_an   = ((k % 8) < 2) ? 4'b1111 : ~exp_code;
      exp_fs   = (k == 32);
      checks += 4;
      if (code !== exp_code) begin
        failures++;
        $display("[TB] FAIL reset_code cycle=%0d got=%b exp=%b", k, code, exp_code);
      end
      if (an !== exp_an) begin
        failures++;
        $display("[TB] FAIL reset_an cycle=%0d got=%b exp=%b", k, an, exp_an);
      end
      if (frame_start !== exp_fs) begin
        failures++;
        $display("[TB] FAIL reset_frame_start cycle=%0d got=%b exp=%b", k, frame_start, exp_fs);
      end
      if ({digit_bcd, digit_blank, pending} !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle=%0d got bcd=%h blank=%b pend=%b exp 0/0/0",
                 k, digit_bcd, digit_blank, pending);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_onehot_invariant;
    for (int k = 0; k < 1000; k++) begin
      checks += 2;
      if ($onehot(code) !== 1'b1) begin
        failures++;
        $display("[TB] FAIL onehot_code cycle=%0d got=%b exp=one-hot", k, code);
      end
      if (an !== 4'b1111 && an !== ~code) begin
        failures++;
        $display("[TB] FAIL onehot_an cycle=%0d got=%b exp=1111 or %b", k, an, ~code);
      end
      rst      = ($urandom_range(0, 24) == 0);
      load     = ($urandom_range(0, 9) == 0);
      score_in = 16'($urandom);
      @(negedge clk);
    end
    rst  = 1'b0;
    load = 1'b0;
  endtask

  task automatic test_double_buffer;
    logic [15:0] val = 16'h1234;
    logic [3:0]  exp_d;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      exp_d = (k < 32) ? 4'h0 : 4'(val >> (4 * ((k / 8) % 4)));
      checks++;
      if (digit_bcd !== exp_d) begin
        failures++;
        $display("[TB] FAIL dbuf_digit cycle=%0d got=%h exp=%h", k, digit_bcd, exp_d);
      end
      if (k == 13 || k == 31 || k == 32) begin
        checks += 2;
        if (pending !== (k != 32)) begin
          failures++;
          $display("[TB] FAIL dbuf_pending cycle=%0d got=%b exp=%b", k, pending, k != 32);
        end
        if (frame_start !== (k == 32)) begin
          failures++;
          $display("[TB] FAIL dbuf_frame_start cycle=%0d got=%b exp=%b", k, frame_start, k == 32);
        end
      end
      load     = (k == 12);
      score_in = (k == 12) ? val : 16'hFFFF;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_d;
    logic       exp_p;
    do_reset();
    for (int k = 0; k < 72; k++) begin
      exp_d = (k < 32) ? 4'h0 : (k < 64) ? 4'h1 : 4'h2;
      exp_p = (k >= 3 && k < 64);
      checks += 3;
      if (digit_bcd !== exp_d) begin
        failures++;
        $display("[TB] FAIL b2b_digit cycle=%0d got=%h exp=%h", k, digit_bcd, exp_d);
      end
      if (pending !== exp_p) begin
        failures++;
        $display("[TB] FAIL b2b_pending cycle=%0d got=%b exp=%b", k, pending, exp_p);
      end
      if (frame_start !== (k == 32 || k == 64)) begin
        failures++;
        $display("[TB] FAIL b2b_frame_start cycle=%0d got=%b exp=%b", k, frame_start, k == 32 || k == 64);
      end
      load = (k == 2 || k == 4 || k == 31);
      score_in = (k == 2) ? 16'h5555 : (k == 4) ? 16'h1111 : (k == 31) ? 16'h2222 : 16'hEEEE;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_midframe_reset;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      load = (k == 5);
      score_in = 16'h9999;
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mfr_pending_before got=%b exp=1", pending);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (code !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL mfr_code got=%b exp=0001", code);
    end
    if (pending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mfr_pending got=%b exp=0", pending);
    end
    if (an !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL mfr_an got=%b exp=1111", an);
    end
    // A discarded score must never reach the display across the following frame boundary.
    for (int k = 0; k < 64; k++) begin
      checks += 2;
      if (digit_bcd !== 4'h0) begin
        failures++;
        $display("[TB] FAIL mfr_digit cycle=%0d got=%h exp=0", k, digit_bcd);
      end
      if (pending !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mfr_pending_after cycle=%0d got=%b exp=0", k, pending);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lzb;
    logic [3:0] slot;
    logic       exp_b;
    logic [3:0] exp_d;
    do_reset();
    for (int k = 0; k < 96; k++) begin
      slot = 4'((k / 8) % 4);
`ifdef SCAN_LZB_EN
      exp_b = (k < 32) ? (slot != 0) : (k < 64) ? (slot >= 2) : (slot != 0);
`else
      exp_b = 1'b0;
`endif
      exp_d = (k >= 32 && k < 64) ? 4'(16'h0042 >> (4 * slot)) : 4'h0;
      checks += 2;
      if (digit_blank !== exp_b) begin
        failures++;
        $display("[TB] FAIL lzb_blank cycle=%0d slot=%0d got=%b exp=%b", k, slot, digit_blank, exp_b);
      end
      if (digit_bcd !== exp_d) begin
        failures++;
        $display("[TB] FAIL lzb_digit cycle=%0d got=%h exp=%h", k, digit_bcd, exp_d);
      end
      load     = (k == 0 || k == 40);
      score_in = (k == 0) ? 16'h0042 : 16'h0000;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_onehot_invariant();
    test_double_buffer();
    test_back_to_back();
    test_midframe_reset();
    test_lzb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
